seq_divider16: RTL and testbench

//  Sequential 16-bit unsigned restoring divider for the ALU divide path.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_shl1.sv | 11 +
 rtl/div_step.sv | 24 ++
 rtl/seq_divider16.sv | 94 +++++++++
 tb/tb_seq_divider16.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;

    localparam int DIV_W     = 16;
    localparam int DIV_CNT_W = 5;

    localparam logic [DIV_W-1:0] DIV_ZERO_Q = {DIV_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_shl1.sv
// One-bit logical left shift of the divider's partial register; a zero enters bit 0.
module div_shl1 #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    output logic [N-1:0] y
);

    assign y = {a[N-2:0], 1'b0};

endmodule

// File: rtl/div_step.sv
// One restoring-division iteration: shift {remainder, quotient} left, then trial-subtract the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [2*W-1:0] p,
    input  logic [W-1:0]   d,
    output logic [2*W-1:0] p_next
);

    logic [2*W-1:0] s;
    logic [W:0]     t;

    div_shl1 #(.N(2*W)) u_shl (
        .a (p),
        .y (s)
    );

    // The extra top bit of t is the borrow: set means the divisor did not fit.
    assign t      = {1'b0, s[2*W-1:W]} - {1'b0, d};
    assign p_next = t[W] ? s : {t[W-1:0], s[W-1:1], 1'b1};

endmodule

// File: rtl/seq_divider16.sv
// Sequential 16-bit unsigned restoring divider: one quotient bit per clock, results on a done pulse.
module seq_divider16
    import div_pkg::*;
#(
    parameter int W     = DIV_W,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_zero
);

    state_t             state, state_nxt;
    logic [2*W-1:0]     p, p_step;
    logic [W-1:0]       d;
    logic [CNT_W-1:0]   cnt;
    logic               accept, last_iter;

    div_step #(.W(W)) u_step (
        .p      (p),
        .d      (d),
        .p_next (p_step)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        accept    = 1'b0;
        last_iter = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                done = (state == S_DONE);
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (divisor == '0) ? S_DONE : S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt == CNT_W'(W - 1)) begin
                    last_iter = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            p         <= '0;
            d         <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                p   <= {{W{1'b0}}, dividend};
                d   <= divisor;
                cnt <= '0;
                // A zero divisor short-circuits straight to a flagged result.
                if (divisor == '0) begin
                    quotient  <= {W{1'b1}};
                    remainder <= dividend;
                    div_zero  <= 1'b1;
                end
            end else if (state == S_RUN) begin
                p   <= p_step;
                cnt <= cnt + 1'b1;
                if (last_iter) begin
                    quotient  <= p_step[W-1:0];
                    remainder <= p_step[2*W-1:W];
                    div_zero  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_divider16.sv
// Self-checking bench: arithmetic reference model compared every cycle, plus directed literal cases.
module tb_seq_divider16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend, divisor;
    logic        busy, done, div_zero;
    logic [15:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    seq_divider16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycles left in the current operation and the results it will deliver.
    int          m_rem = 0;
    logic        m_done = 1'b0;
    logic        m_dz = 1'b0;
    logic [15:0] m_q = '0, m_r = '0, m_pq = '0, m_pr = '0;
    bit          cmp_en = 1'b0;

    always @(posedge clk) begin : model
        logic nd;
        nd = 1'b0;
        if (rst_n !== 1'b1) begin
            m_rem = 0;
            m_q   = '0;
            m_r   = '0;
            m_dz  = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                nd   = 1'b1;
                m_q  = m_pq;
                m_r  = m_pr;
                m_dz = 1'b0;
            end
        end else if (start === 1'b1) begin
            if (divisor == 16'd0) begin
                nd   = 1'b1;
                m_q  = 16'hFFFF;
                m_r  = dividend;
                m_dz = 1'b1;
            end else begin
                m_rem = 16;
                m_pq  = dividend / divisor;
                m_pr  = dividend % divisor;
            end
        end
        m_done = nd;
    end

    always @(negedge clk) begin : compare
        if (cmp_en) begin
            check("busy", busy, (m_rem > 0));
            check("done", done, m_done);
            if (m_rem == 0) begin
                check("quotient", quotient, m_q);
                check("remainder", remainder, m_r);
                check("div_zero", div_zero, m_dz);
            end
        end
    end

    // Waits (bounded) for done; lat counts clock edges after the accept edge.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) check("done_timeout", 0, 1);
    endtask

    // Called at a negedge with the divider idle or on its done cycle.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int exp_lat,
                         input logic [15:0] eq, input logic [15:0] er, input logic edz);
        int lat, bcnt;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
        wait_done(lat, bcnt);
        check("done_edge_offset", lat, exp_lat);
        check("busy_cycles", bcnt, (exp_lat == 0) ? 0 : 16);
        check("lit_quotient", quotient, eq);
        check("lit_remainder", remainder, er);
        check("lit_div_zero", div_zero, edz);
        check("model_quotient", m_q, eq);
        check("model_remainder", m_r, er);
    endtask

    initial begin
        int lat, bcnt, ndone;
        bit seen;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_quotient", quotient, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(16'd100, 16'd7, 16, 16'd14, 16'd2, 1'b0);
        @(negedge clk);
        do_op(16'hFFFF, 16'd1, 16, 16'hFFFF, 16'd0, 1'b0);
        do_op(16'd3, 16'd10, 16, 16'd0, 16'd3, 1'b0);
        do_op(16'h8000, 16'h8000, 16, 16'd1, 16'd0, 1'b0);
        @(negedge clk);
        do_op(16'd5, 16'd0, 0, 16'hFFFF, 16'd5, 1'b1);
        @(negedge clk);

        // start while busy must be ignored
        start = 1'b1; dividend = 16'd1000; divisor = 16'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; dividend = 16'd9; divisor = 16'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bcnt);
        check("busy_start_quotient", quotient, 16'd333);
        check("busy_start_remainder", remainder, 16'd1);
        @(negedge clk);

        // reset in the middle of an operation
        start = 1'b1; dividend = 16'd50000; divisor = 16'd123;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_div_zero", div_zero, 0);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check("no_done_after_reset", seen, 0);
        do_op(16'd7, 16'd2, 16, 16'd3, 16'd1, 1'b0);
        @(negedge clk);

        // back-to-back: second start on the done cycle of the first
        do_op(16'd100, 16'd7, 16, 16'd14, 16'd2, 1'b0);
        do_op(16'd200, 16'd9, 16, 16'd22, 16'd2, 1'b0);
        @(negedge clk);

        // randomized traffic against the model
        ndone = 0;
        for (int i = 0; i < 3000; i++) begin
            int sel;
            rst_n    = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
            start    = ($urandom_range(0, 2) == 0);
            dividend = 16'($urandom);
            sel      = $urandom_range(0, 9);
            if (sel == 0)      divisor = 16'd0;
            else if (sel < 4)  divisor = 16'($urandom_range(1, 15));
            else if (sel == 4) divisor = 16'h8000 | 16'($urandom);
            else               divisor = 16'($urandom);
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        start = 1'b0;
        rst_n = 1'b1;
        check("random_results_seen", (ndone > 20), 1);
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
